// File: rtl/qpp_interleaver_if.sv
`default_nettype none
// ------------------------------------------------------------------
// qpp_interleaver_if : block-load / dual-stream bus of the QPP feeder
// rev 1.0
// ------------------------------------------------------------------
interface qpp_interleaver_if;
  logic in_valid;
  logic in_bit;
  logic in_first;
  logic k_sel;
  logic in_ready;
  logic data_ready;
  logic K;
  logic ck;
  logic ck_int;
  logic out_valid;
  logic busy;

  modport master (
    output in_valid, in_bit, in_first, k_sel,
    input  in_ready, data_ready, K, ck, ck_int, out_valid, busy
  );

  modport slave (
    input  in_valid, in_bit, in_first, k_sel,
    output in_ready, data_ready, K, ck, ck_int, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/qpp_interleaver.sv
`default_nettype none
// ------------------------------------------------------------------
// qpp_interleaver : buffers one LTE code block, streams natural and
// QPP-interleaved bits to the turbo constituent encoders. rev 1.0
// ------------------------------------------------------------------
module qpp_interleaver #(
  parameter int K_SMALL  = 1056,
  parameter int F1_SMALL = 17,
  parameter int F2_SMALL = 66,
  parameter int K_LARGE  = 6144,
  parameter int F1_LARGE = 263,
  parameter int F2_LARGE = 480,
  parameter int TAIL_GAP = 4,
  parameter int AW       = 13
) (
  input  wire logic         clk,
  input  wire logic         aclr,
  qpp_interleaver_if.slave  qif
);

  localparam int DW = $clog2(TAIL_GAP + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_ANNOUNCE = 3'd2;
  localparam logic [2:0] S_STREAM   = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;

  localparam logic [AW:0] c_ONE   = (AW+1)'(1);
  localparam logic [AW:0] c_KS    = (AW+1)'(K_SMALL);
  localparam logic [AW:0] c_KL    = (AW+1)'(K_LARGE);
  localparam logic [AW:0] c_G0_S  = (AW+1)'((F1_SMALL + F2_SMALL) % K_SMALL);
  localparam logic [AW:0] c_G0_L  = (AW+1)'((F1_LARGE + F2_LARGE) % K_LARGE);
  localparam logic [AW:0] c_D2_S  = (AW+1)'((2 * F2_SMALL) % K_SMALL);
  localparam logic [AW:0] c_D2_L  = (AW+1)'((2 * F2_LARGE) % K_LARGE);
  localparam logic [DW-1:0] c_D_ONE  = DW'(1);
  localparam logic [DW-1:0] c_D_LAST = DW'(TAIL_GAP - 1);

  logic [2:0]    r_state;
  logic          r_K;
  logic [AW:0]   r_wcnt;
  logic [AW:0]   r_na;
  logic [AW:0]   r_pa;
  logic [AW:0]   r_g;
  logic [DW-1:0] r_dcnt;
  logic          r_ck;
  logic          r_ck_int;
  logic          r_out_valid;
  logic          r_mem [0:K_LARGE-1];

  logic [AW:0]   w_kb;
  logic [AW:0]   w_last;
  logic [AW:0]   w_g0;
  logic [AW:0]   w_d2;
  logic [AW:0]   w_psum;
  logic [AW:0]   w_gsum;
  logic [AW:0]   w_pnext;
  logic [AW:0]   w_gnext;
  logic          w_in_ready;
  logic          w_we;
  logic [AW-1:0] w_waddr;

  assign w_kb   = r_K ? c_KL : c_KS;
  assign w_last = w_kb - c_ONE;
  assign w_g0   = r_K ? c_G0_L : c_G0_S;
  assign w_d2   = r_K ? c_D2_L : c_D2_S;

  // Both addends are below Kb, so one conditional subtract completes the mod.
  assign w_psum  = r_pa + r_g;
  assign w_gsum  = r_g + w_d2;
  assign w_pnext = (w_psum >= w_kb) ? (w_psum - w_kb) : w_psum;
  assign w_gnext = (w_gsum >= w_kb) ? (w_gsum - w_kb) : w_gsum;

  assign w_in_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_we       = w_in_ready && qif.in_valid && (qif.in_first || (r_state == S_LOAD));
  assign w_waddr    = qif.in_first ? '0 : r_wcnt[AW-1:0];

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= qif.in_bit;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_state     <= S_IDLE;
      r_K         <= 1'b0;
      r_wcnt      <= '0;
      r_na        <= '0;
      r_pa        <= '0;
      r_g         <= '0;
      r_dcnt      <= '0;
      r_ck        <= 1'b0;
      r_ck_int    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (qif.in_valid && qif.in_first) begin
            r_K     <= qif.k_sel;
            r_wcnt  <= c_ONE;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (qif.in_valid) begin
            if (qif.in_first) begin
              r_K    <= qif.k_sel;
              r_wcnt <= c_ONE;
            end else if (r_wcnt == w_last) begin
              r_na    <= '0;
              r_pa    <= '0;
              r_g     <= w_g0;
              r_state <= S_ANNOUNCE;
            end else begin
              r_wcnt <= r_wcnt + c_ONE;
            end
          end
        end
        S_ANNOUNCE, S_STREAM: begin
          // Addresses run one cycle ahead so the outputs come straight from flops.
          if ((r_state == S_STREAM) && (r_na == w_kb)) begin
            r_ck        <= 1'b0;
            r_ck_int    <= 1'b0;
            r_out_valid <= 1'b0;
            r_dcnt      <= '0;
            r_state     <= S_DRAIN;
          end else begin
            r_ck        <= r_mem[r_na[AW-1:0]];
            r_ck_int    <= r_mem[r_pa[AW-1:0]];
            r_out_valid <= 1'b1;
            r_na        <= r_na + c_ONE;
            r_pa        <= w_pnext;
            r_g         <= w_gnext;
            r_state     <= S_STREAM;
          end
        end
        S_DRAIN: begin
          if (r_dcnt == c_D_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_dcnt <= r_dcnt + c_D_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign qif.in_ready   = w_in_ready;
  assign qif.data_ready = (r_state == S_ANNOUNCE);
  assign qif.busy       = (r_state == S_ANNOUNCE) || (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign qif.K          = r_K;
  assign qif.ck         = r_ck;
  assign qif.ck_int     = r_ck_int;
  assign qif.out_valid  = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_qpp_interleaver.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_qpp_interleaver : directed self-checking bench for qpp_interleaver
// rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qpp_interleaver;

  localparam int KS  = 40;
  localparam int F1S = 3;
  localparam int F2S = 10;
  localparam int KL  = 6144;
  localparam int F1L = 263;
  localparam int F2L = 480;
  localparam int TG  = 4;

  logic clk  = 1'b0;
  logic aclr = 1'b1;
  always #5 clk = ~clk;

  qpp_interleaver_if bus ();

  qpp_interleaver #(
    .K_SMALL  (KS),
    .F1_SMALL (F1S),
    .F2_SMALL (F2S)
  ) dut (
    .clk  (clk),
    .aclr (aclr),
    .qif  (bus)
  );

  int   n_total = 0;
  int   n_bad   = 0;
  logic data   [0:KL-1];
  logic cap_ck [0:KL-1];
  logic cap_ci [0:KL-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pi_ref(input int i, input int k, input int f1, input int f2);
    longint li;
    li = longint'(i);
    return int'((longint'(f1) * li + longint'(f2) * li * li) % longint'(k));
  endfunction

  function automatic int first_one_ci(input int n);
    for (int i = 0; i < n; i++) if (cap_ci[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int first_one_ck(input int n);
    for (int i = 0; i < n; i++) if (cap_ck[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int ones_ci(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (cap_ci[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic fill(input int mode, input int pos);
    for (int i = 0; i < KL; i++) begin
      case (mode)
        0:       data[i] = (i == pos);
        1:       data[i] = 1'b1;
        default: data[i] = 1'($urandom);
      endcase
    end
  endtask

  // Returns at the negedge of the cycle after the last accepted bit.
  task automatic send(input logic ks, input int n, input logic hold);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_first = (i == 0);
      bus.in_bit   = data[i];
      bus.k_sel    = ks;
    end
    @(negedge clk);
    bus.in_valid = hold;
    bus.in_first = 1'b0;
    bus.in_bit   = 1'b1;
  endtask

  task automatic stream(input string tg, input int kb, input logic kexp, input int f1, input int f2);
    int nv, ndr, nk, nd, eck, eci;
    nv = 0; ndr = 0; nk = 0; nd = 0; eck = 0; eci = 0;
    check({tg, ".data_ready"}, 32'(bus.data_ready), 32'd1);
    check({tg, ".announce"}, {29'd0, bus.busy, bus.in_ready, bus.out_valid}, 32'b100);
    check({tg, ".K"}, 32'(bus.K), 32'(kexp));
    for (int i = 0; i < kb; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) nv++;
      if (bus.data_ready !== 1'b0) ndr++;
      if (bus.K !== kexp) nk++;
      cap_ck[i] = bus.ck;
      cap_ci[i] = bus.ck_int;
    end
    check({tg, ".valid_cycles"}, 32'(nv), 32'(kb));
    check({tg, ".extra_pulses"}, 32'(ndr), 32'd0);
    check({tg, ".K_unstable"}, 32'(nk), 32'd0);
    for (int d = 0; d < TG; d++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.ck !== 1'b0 || bus.ck_int !== 1'b0 ||
          bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.K !== kexp) nd++;
    end
    check({tg, ".drain_bad"}, 32'(nd), 32'd0);
    @(negedge clk);
    check({tg, ".idle"}, {29'd0, bus.in_ready, bus.busy, bus.out_valid}, 32'b100);
    bus.in_valid = 1'b0;
    for (int i = 0; i < kb; i++) begin
      if (cap_ck[i] !== data[i]) eck++;
      if (cap_ci[i] !== data[pi_ref(i, kb, f1, f2)]) eci++;
    end
    check({tg, ".ck_errs"}, 32'(eck), 32'd0);
    check({tg, ".ck_int_errs"}, 32'(eci), 32'd0);
  endtask

  int t2_bit [3] = '{13, 6, 19};
  int t2_pos [3] = '{1, 2, 3};

  initial begin
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_first = 1'b0;
    bus.k_sel    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.outputs",
          {25'd0, bus.in_ready, bus.data_ready, bus.K, bus.ck, bus.ck_int, bus.out_valid, bus.busy},
          32'b1000000);
    aclr = 1'b0;

    // single one at bit 0
    fill(0, 0);
    send(1'b0, KS, 1'b0);
    stream("t1", KS, 1'b0, F1S, F2S);
    check("t1.ck_pos", 32'(first_one_ck(KS)), 32'd0);
    check("t1.ck_int_pos", 32'(first_one_ci(KS)), 32'd0);
    check("t1.ck_int_ones", 32'(ones_ci(KS)), 32'd1);

    // pi(1)=13, pi(2)=6, pi(3)=19
    for (int t = 0; t < 3; t++) begin
      fill(0, t2_bit[t]);
      send(1'b0, KS, 1'b0);
      stream("t2", KS, 1'b0, F1S, F2S);
      check("t2.ck_pos", 32'(first_one_ck(KS)), 32'(t2_bit[t]));
      check("t2.ck_int_pos", 32'(first_one_ci(KS)), 32'(t2_pos[t]));
    end

    // random data, two blocks of each size back to back
    for (int b = 0; b < 2; b++) begin
      fill(2, 0);
      send(1'b0, KS, 1'b0);
      stream("t3s", KS, 1'b0, F1S, F2S);
    end
    for (int b = 0; b < 2; b++) begin
      fill(2, 0);
      send(1'b1, KL, 1'b0);
      stream("t3l", KL, 1'b1, F1L, F2L);
    end

    // restart at bit 20 with k_sel toggled
    fill(1, 0);
    send(1'b0, 20, 1'b0);
    check("t4.still_loading", {30'd0, bus.in_ready, bus.busy}, 32'b10);
    fill(2, 0);
    send(1'b1, KL, 1'b0);
    stream("t4", KL, 1'b1, F1L, F2L);

    // aclr during STREAM at i=10, K was 1 before the reset
    fill(2, 0);
    send(1'b1, KL, 1'b0);
    check("t5.data_ready", 32'(bus.data_ready), 32'd1);
    repeat (11) @(negedge clk);
    check("t5.mid_stream", {30'd0, bus.out_valid, bus.busy}, 32'b11);
    aclr = 1'b1;
    @(negedge clk);
    check("t5.after_aclr",
          {26'd0, bus.out_valid, bus.busy, bus.in_ready, bus.data_ready, bus.K, bus.ck},
          32'b001000);
    aclr = 1'b0;
    fill(2, 0);
    send(1'b0, KS, 1'b0);
    stream("t5b", KS, 1'b0, F1S, F2S);

    // in_valid held high with in_bit=1 through ANNOUNCE/STREAM/DRAIN
    fill(0, 5);
    send(1'b0, KS, 1'b1);
    stream("t6", KS, 1'b0, F1S, F2S);
    check("t6.ck_pos", 32'(first_one_ck(KS)), 32'd5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
